uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin scheduler that shares the single UART transmitter among `N_REQ` byte-stream requesters. Each requester offers packets over a valid/ready/last interface. The scheduler grants one requester for a whole packet and feeds its bytes to the transmitter's `din`/`wr_en` inputs, pacing itself on `tx_busy`. It sits between the client logic and the transmitter inside the UART top level and shares `clk_50m` with it.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ACK_TO`, 4: cycles allowed for `tx_busy` to rise after `tx_wr_en`.
- `clk_50m`  in  1  system clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a byte on offer.
- `req_data`  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- `req_last`  in  N_REQ  offered byte is the last byte of its packet.
- `req_ready`  out  N_REQ  one-hot, single-cycle; the byte is taken at this edge.
- `grant`  out  N_REQ  one-hot owner of the transmitter; 0 when idle.
- `tx_din`  out  8  byte to the transmitter; held between loads.
- `tx_wr_en`  out  1  single-cycle write strobe to the transmitter.
- `tx_busy`  in  1  transmitter busy.
- `ack_err`  out  1  single-cycle pulse when an ACK timeout occurs.

## Operation
- States:
  - IDLE: no owner.
  - LOAD: one cycle; `tx_wr_en`, `req_ready[g]` and `tx_din` are driven.
  - WAIT_ACK: waiting for `tx_busy` to go to 1.
  - WAIT_DONE: waiting for `tx_busy` to go to 0.
  - HOLD: owner still holds the grant but has no valid byte.
- IDLE → LOAD when `tx_busy`=0 and any `req_valid` is 1.
  - Winner: first set bit searching upward from `ptr`, wrapping modulo N_REQ.
  - `grant` and `tx_din` are registered on this edge.
- LOAD → WAIT_ACK unconditionally.
- WAIT_ACK → WAIT_DONE when `tx_busy`=1.
  - If `tx_busy` stays 0 for ACK_TO cycles: pulse `ack_err` and treat the byte as sent (go to the WAIT_DONE exit decision).
- WAIT_DONE exit when `tx_busy`=0:
  - If the byte was last: `ptr` ← g+1 mod N_REQ, `grant` ← 0, go to IDLE.
  - Else if `req_valid[g]`: go to LOAD with the next byte.
  - Else: go to HOLD.
- HOLD → LOAD when `req_valid[g]`=1. There is no timeout; packets are atomic and other requesters wait.
- The last flag is captured in LOAD from `req_last[g]`.
- Requester contract: keep valid/data/last stable until `req_ready` is seen. `req_valid` of non-owners is ignored while a packet is in progress.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant`=0, `req_ready`=0, `tx_wr_en`=0, `tx_din`=0x00, `ack_err`=0.
- All outputs are registered.
- Latency:
  - `req_valid` seen in IDLE at edge k → `tx_wr_en`=1 and `req_ready[g]`=1 during cycle k+1 only.
  - Byte-to-byte gap within a packet: 1 cycle after `tx_busy` falls.
- `tx_busy` is already 1 when in IDLE (e.g. after a reset mid-frame): no grant until it reads 0.
- Reset asserted mid-packet: immediate return to IDLE with all outputs at reset values. The partially sent packet is abandoned and no further bytes of it are taken.
- Simultaneous valid on all requesters: served in order ptr, ptr+1, … with exactly one packet each per rotation.
- Wrap-around: owner N_REQ-1 finishing sets `ptr`=0.

## Structure
- Shared UART package holds:
  - state encoding typedef (IDLE, LOAD, WAIT_ACK, WAIT_DONE, HOLD);
  - byte width constant 8;
  - default ACK_TO.
- One sub-module: `rr_pick`, a combinational round-robin one-hot selector taking `req_valid` and `ptr` and returning a one-hot winner. Reusable by a future RX dispatch block.

## Test plan
- Single byte 0xA5 on req 0 with `last` set:
  - one `tx_wr_en` pulse with `tx_din`=0xA5;
  - `req_ready[0]` in the same cycle;
  - `grant` returns to 0 after `tx_busy` falls;
  - `ptr`=1.
- Reqs 0 and 2 each offer a one-byte packet at the same edge after reset: req 0 is served first, then req 2; `ptr` ends at 3.
- Req 1 offers a 3-byte packet 0x11/0x22/0x33 while req 3 asserts valid: all three bytes go out back-to-back before any byte of req 3.
- Req 1 drops valid for 20 cycles after byte 1 while req 0 is valid:
  - HOLD keeps `grant`=0b0010 the whole time;
  - byte 2 is sent when valid returns.
- Transmitter model never raises `tx_busy`: `ack_err` pulses ACK_TO cycles after `tx_wr_en` and the next byte is loaded.
- `rst_n` low in WAIT_DONE of byte 2 of 4, with `tx_busy` held high 10 more cycles:
  - all outputs read reset values;
  - no `tx_wr_en` until `tx_busy`=0;
  - the next grant starts from `ptr`=0.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared UART package: byte width, scheduler
// state encoding and default ACK timeout.
package uart_tx_sched_pkg;

    localparam int BYTE_W     = 8;
    localparam int ACK_TO_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_HOLD
    } tx_state_e;

    // Width of a pointer into n requesters (at least 1 bit).
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin one-hot selector:
// first set request at or above ptr, wrapping.
module rr_pick
    import uart_tx_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);

    // Scan upward from ptr and keep only the first hit.
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler feeding the single
// UART transmitter from N_REQ byte-stream requesters.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ACK_TO = ACK_TO_DEF
) (
    input  logic                    clk_50m,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic [BYTE_W-1:0]       tx_din,
    output logic                    tx_wr_en,
    input  logic                    tx_busy,
    output logic                    ack_err
);

    localparam int PW = ptr_w(N_REQ);
    localparam int CW = $clog2(ACK_TO + 1);

    tx_state_e          state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [PW-1:0]      ptr_nxt;
    logic [CW-1:0]      ack_cnt;
    logic               last_q;
    logic [N_REQ-1:0]   win;
    logic [BYTE_W-1:0]  win_data;
    logic [BYTE_W-1:0]  own_data;
    logic               own_valid;
    logic               own_last;
    logic               ack_hit;
    logic               ack_fire;
    logic               byte_done;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .win (win)
    );

    // Select winner and owner lanes; decide when the current byte is finished.
    always_comb begin
        win_data = '0;
        own_data = '0;
        own_last = 1'b0;
        gidx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_data = win_data | req_data[i*BYTE_W +: BYTE_W];
            end
            if (grant[i]) begin
                own_data = own_data | req_data[i*BYTE_W +: BYTE_W];
                own_last = own_last | req_last[i];
                gidx     = PW'(i);
            end
        end
        own_valid = |(req_valid & grant);
        ptr_nxt   = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
        // Timeout fires after ACK_TO WAIT_ACK cycles with tx_busy low.
        ack_hit   = (ack_cnt == CW'(ACK_TO - 1));
        ack_fire  = (state == ST_WAIT_ACK) && !tx_busy && ack_hit;
        byte_done = ((state == ST_WAIT_DONE) && !tx_busy) || ack_fire;
    end

    // Scheduler FSM with registered grant, strobes and data.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant     <= '0;
            req_ready <= '0;
            tx_wr_en  <= 1'b0;
            tx_din    <= '0;
            ack_err   <= 1'b0;
            ack_cnt   <= '0;
            last_q    <= 1'b0;
        end else begin
            tx_wr_en  <= 1'b0;
            req_ready <= '0;
            ack_err   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!tx_busy && |req_valid) begin
                        state     <= ST_LOAD;
                        grant     <= win;
                        tx_din    <= win_data;
                        tx_wr_en  <= 1'b1;
                        req_ready <= win;
                    end
                end
                ST_LOAD: begin
                    last_q  <= own_last;
                    ack_cnt <= '0;
                    state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (!ack_hit) begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    state <= ST_WAIT_DONE;
                end
                ST_HOLD: begin
                    if (own_valid) begin
                        state     <= ST_LOAD;
                        tx_din    <= own_data;
                        tx_wr_en  <= 1'b1;
                        req_ready <= grant;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Shared exit for a normally finished or timed-out byte.
            if (byte_done) begin
                if (last_q) begin
                    state <= ST_IDLE;
                    grant <= '0;
                    ptr   <= ptr_nxt;
                end else if (own_valid) begin
                    state     <= ST_LOAD;
                    tx_din    <= own_data;
                    tx_wr_en  <= 1'b1;
                    req_ready <= grant;
                end else begin
                    state <= ST_HOLD;
                end
                ack_err <= ack_fire;
            end
        end
    end

endmodule
